// File: rtl/frv_dmem_arbiter_if.sv
// frv_dmem_arbiter_if: one data-memory bus (request, write fields, grant,
// response). The arbiter takes two upstream buses on the slave modport and
// drives the shared downstream bus through the master modport.
//   req/wen/strb/wdata/addr : request and write fields, from the master
//   gnt                     : request accepted this cycle, to the master
//   recv/error/rdata        : response valid, error flag and read data
//   ack                     : master accepts the response
interface frv_dmem_arbiter_if #(
  parameter int XL = 31
);
  logic          req;
  logic          wen;
  logic [3:0]    strb;
  logic [XL:0]   wdata;
  logic [XL:0]   addr;
  logic          gnt;
  logic          recv;
  logic          ack;
  logic          error;
  logic [XL:0]   rdata;

  modport master (
    output req, wen, strb, wdata, addr, ack,
    input  gnt, recv, error, rdata
  );

  modport slave (
    input  req, wen, strb, wdata, addr, ack,
    output gnt, recv, error, rdata
  );
endinterface

// File: rtl/frv_dmem_arbiter.sv
// frv_dmem_arbiter: shares one data-memory bus between the LSU (p0) and a
// secondary master (p1). The request path is purely combinational (no added
// latency). Granted transactions push their port ID into a small FIFO so
// in-order responses are steered back to the right requester.
//   g_clk, g_reset : clock, synchronous active-high reset
//   p0, p1         : upstream buses (slave side of frv_dmem_arbiter_if)
//   dmem           : downstream bus (master side of frv_dmem_arbiter_if)
module frv_dmem_arbiter #(
  parameter int XL              = 31,
  parameter int MAX_OUTSTANDING = 2,
  parameter bit FIXED_PRIORITY  = 1'b0
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  frv_dmem_arbiter_if.slave     p0,
  frv_dmem_arbiter_if.slave     p1,
  frv_dmem_arbiter_if.master    dmem
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(MAX_OUTSTANDING);

  logic                       sel, sel_q, lock, last;
  logic                       sel_req, full, push, pop, busy, head;
  logic [MAX_OUTSTANDING-1:0] id_fifo;
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [PW:0]                count;

  // A port that was offered but not granted keeps ownership until its gnt,
  // so the downstream request fields never change mid-handshake.
  always_comb begin
    sel = 1'b0;
    if (lock)                   sel = sel_q;
    else if (p0.req && p1.req)  sel = FIXED_PRIORITY ? 1'b0 : ~last;
    else if (p1.req)            sel = 1'b1;
  end

  assign sel_req    = sel ? p1.req : p0.req;
  assign full       = (count == CNT_FULL);
  // Full check uses the registered count only: no path from dmem.recv to req.
  assign dmem.req   = sel_req && !full;
  assign dmem.wen   = sel ? p1.wen   : p0.wen;
  assign dmem.strb  = sel ? p1.strb  : p0.strb;
  assign dmem.wdata = sel ? p1.wdata : p0.wdata;
  assign dmem.addr  = sel ? p1.addr  : p0.addr;

  assign push   = dmem.req && dmem.gnt;
  assign p0.gnt = push && !sel;
  assign p1.gnt = push &&  sel;

  // Response steering: the FIFO head names the owner of the next response.
  assign busy     = (count != '0);
  assign head     = id_fifo[rd_ptr];
  assign p0.recv  = busy && !head && dmem.recv;
  assign p1.recv  = busy &&  head && dmem.recv;
  assign p0.error = busy && !head && dmem.error;
  assign p1.error = busy &&  head && dmem.error;
  assign dmem.ack = busy && (head ? p1.ack : p0.ack);
  assign p0.rdata = dmem.rdata;
  assign p1.rdata = dmem.rdata;
  assign pop      = dmem.recv && dmem.ack;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      sel_q  <= 1'b0;
      lock   <= 1'b0;
      last   <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      sel_q <= sel;
      lock  <= dmem.req && !dmem.gnt;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        last   <= sel;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ID storage needs no reset: entries are only read while count > 0.
  always_ff @(posedge g_clk) begin
    if (!g_reset && push) id_fifo[wr_ptr] <= sel;
  end

  // A locked requester must hold req until granted.
  a_hold_req: assert property (@(posedge g_clk) disable iff (g_reset)
    lock |-> sel_req);
  // A response with nothing outstanding is a downstream protocol error.
  a_recv_idle: assert property (@(posedge g_clk) disable iff (g_reset)
    dmem.recv |-> busy);

endmodule
